// File: rtl/modinv_pkg.sv
// Shared types and helpers for the modular inverse block.
// Optional self-check build: define MODINV_CHECK_EN.
package modinv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SQR_ISS,
    SQR_WB,
    MUL_ISS,
    MUL_WB,
    CHK_ISS,
    CHK_WB,
    DONE
  } modinv_state_e;

`ifdef MODINV_CHECK_EN
  localparam int unsigned CHK_CYCLES = 2;
`else
  localparam int unsigned CHK_CYCLES = 0;
`endif

  // Accept-to-out_valid cycle count for a given operand width.
  function automatic int unsigned modinv_latency(input int unsigned dw);
    return 4 * dw + 1 + CHK_CYCLES;
  endfunction

  // Width of the exponent bit index, $clog2(DATA_WIDTH) with a floor of 1.
  function automatic int unsigned modinv_idx_width(input int unsigned dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/modular_inverse_if.sv
// Valid/ready request and response bundle for the modular inverse block.
interface modular_inverse_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] modulus;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  err;

  modport master (
    output in_valid, a, modulus, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, a, modulus, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/modular_inverse_mod_mul_seq.sv
// Registered modular multiplier: p = (x*y) mod modulus, one cycle latency.
module mod_mul_seq #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] modulus,
  output logic [DATA_WIDTH-1:0] p
);
  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] mod_ext;

  assign prod    = {{DATA_WIDTH{1'b0}}, x} * {{DATA_WIDTH{1'b0}}, y};
  assign mod_ext = {{DATA_WIDTH{1'b0}}, modulus};

  // Register the reduced product; a zero modulus (illegal input) yields 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      p <= '0;
    else if (modulus == '0)
      p <= '0;
    else
      p <= DATA_WIDTH'(prod % mod_ext);
  end
endmodule

// File: rtl/modular_inverse.sv
// Modular inverse r = a^(q-2) mod q by constant-time square-and-multiply.
// Optional self-check (a*r mod q == 1) enabled by defining MODINV_CHECK_EN.
module modular_inverse
  import modinv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MODULUS_WIDTH = DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  modular_inverse_if.slave   bus
);
  localparam int unsigned IW = modinv_idx_width(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  modinv_state_e         state, state_nxt;
  logic [DATA_WIDTH-1:0] acc, a_q, q_q, e_q;
  logic [IW-1:0]         idx;
  logic                  bad_q;
  logic                  out_valid_q, err_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] mul_x, mul_y, prod;
  logic                  in_ready_c, accept, illegal, fail;
`ifdef MODINV_CHECK_EN
  logic                  chk_ok;
`endif

  assign accept  = bus.in_valid && in_ready_c;
  // Bits above MODULUS_WIDTH mark an out-of-range modulus.
  assign illegal = (bus.a == '0) || (bus.a >= bus.modulus) ||
                   (bus.modulus < DATA_WIDTH'(3)) ||
                   ((bus.modulus >> MODULUS_WIDTH) != '0);
`ifdef MODINV_CHECK_EN
  assign fail = bad_q || !chk_ok;
`else
  assign fail = bad_q;
`endif

  mod_mul_seq #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .x       (mul_x),
    .y       (mul_y),
    .modulus (q_q),
    .p       (prod)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: fixed schedule of four states per exponent bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SQR_ISS;
      SQR_ISS: state_nxt = SQR_WB;
      SQR_WB:  state_nxt = MUL_ISS;
      MUL_ISS: state_nxt = MUL_WB;
      MUL_WB: begin
        if (idx != '0)
          state_nxt = SQR_ISS;
        else
`ifdef MODINV_CHECK_EN
          state_nxt = CHK_ISS;
`else
          state_nxt = DONE;
`endif
      end
`ifdef MODINV_CHECK_EN
      CHK_ISS: state_nxt = CHK_WB;
      CHK_WB:  state_nxt = DONE;
`endif
      DONE:    if (out_valid_q && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: ready gating and multiplier operand selection.
  always_comb begin
    in_ready_c = (state == IDLE) && rst;
    mul_x      = acc;
    mul_y      = a_q;
    case (state)
      SQR_ISS: mul_y = acc;
      CHK_ISS: begin
        mul_x = a_q;
        mul_y = acc;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      a_q         <= '0;
      q_q         <= '0;
      e_q         <= '0;
      idx         <= '0;
      bad_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
`ifdef MODINV_CHECK_EN
      chk_ok      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q   <= bus.a;
          q_q   <= bus.modulus;
          e_q   <= bus.modulus - DATA_WIDTH'(2);
          acc   <= DATA_WIDTH'(1);
          idx   <= LAST_IDX;
          bad_q <= illegal;
        end
        SQR_WB: acc <= prod;
        // Multiply always runs; its product is kept only for set exponent bits.
        MUL_WB: begin
          if (e_q[idx]) acc <= prod;
          if (idx != '0) idx <= idx - 1'b1;
        end
`ifdef MODINV_CHECK_EN
        CHK_WB: chk_ok <= (prod == DATA_WIDTH'(1));
`endif
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= fail ? '0 : acc;
            err_q       <= fail;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_modular_inverse.sv
// Scoreboard bench for modular_inverse with DATA_WIDTH=8, q=17 vectors.
module tb_modular_inverse;
  import modinv_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = modinv_latency(DW);

  typedef struct {
    logic [7:0] a;
    logic [7:0] q;
    logic [7:0] res;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  modular_inverse_if #(.DATA_WIDTH(DW)) bus ();

  modular_inverse #(.DATA_WIDTH(DW), .MODULUS_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  int unsigned acc_cyc_q[$];
  int unsigned cyc     = 0;
  int unsigned last_hs = 0;
  int          checks  = 0;
  int          errors  = 0;
  bit          prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: latency at each out_valid rise, result/err at each handshake.
  always @(negedge clk) begin
    int unsigned a0;
    exp_t e;
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (acc_cyc_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          a0 = acc_cyc_q.pop_front();
          check("latency", cyc - a0, LAT);
        end
      end
      prev_valid = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        last_hs = cyc + 1;
        if (exp_q.size() == 0) check("extra_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("result", bus.result, e.res);
          check("err", bus.err, e.err);
          if (!e.err)
            check("inverse_product", (int'(e.a) * int'(bus.result)) % int'(e.q), 1);
        end
      end
    end
  end

  // Present one operation; returns at posedge+1 after the accept edge, in_valid left high.
  task automatic issue(input logic [7:0] a, input logic [7:0] q, input logic [7:0] res,
                       input logic err, input bit b2b);
    int n = 0;
    bus.a        = a;
    bus.modulus  = q;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    if (b2b) check("b2b_accept_cycle", cyc + 1, last_hs + 1);
    exp_q.push_back('{a, q, res, err});
    acc_cyc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 0, 1);
      exp_q.delete();
      acc_cyc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] inv17 [1:16] = '{8'd1, 8'd9, 8'd6, 8'd13, 8'd7, 8'd3, 8'd5, 8'd15,
                               8'd2, 8'd12, 8'd14, 8'd10, 8'd4, 8'd11, 8'd8, 8'd16};

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.modulus   = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_err", bus.err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic vectors; later ones back-to-back with in_valid held.
    issue(8'd3, 8'd17, 8'd6, 1'b0, 1'b0);
    drain();
    issue(8'd1, 8'd17, 8'd1, 1'b0, 1'b0);
    issue(8'd16, 8'd17, 8'd16, 1'b0, 1'b1);
    issue(8'd2, 8'd17, 8'd9, 1'b0, 1'b1);
    drain();

    // Illegal inputs: same latency, result 0, err 1.
    issue(8'd0, 8'd17, 8'd0, 1'b1, 1'b0);
    issue(8'd20, 8'd17, 8'd0, 1'b1, 1'b1);
    issue(8'd1, 8'd2, 8'd0, 1'b1, 1'b1);
    drain();

    // Full sweep over q=17, back-to-back.
    for (int i = 1; i <= 16; i++)
      issue(8'(i), 8'd17, inv17[i], 1'b0, (i != 1));
    drain();

    // Output stall: result held, busy input ignored.
    bus.out_ready = 1'b0;
    issue(8'd3, 8'd17, 8'd6, 1'b0, 1'b0);
    bus.a = 8'd2;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("stall_out_valid_seen", bus.out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_result", bus.result, 6);
      check("stall_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    issue(8'd2, 8'd17, 8'd9, 1'b0, 1'b0);
    drain();

    // Reset mid-operation aborts with no output.
    issue(8'd7, 8'd17, 8'd5, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_cyc_q.pop_back());
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_result", bus.result, 0);
    check("abort_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(8'd5, 8'd17, 8'd7, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
